// File: rtl/aoi_truth_scanner.sv
// aoi_truth_scanner
// Drives all 32 input vectors of a five-input AND-OR-INVERT gate, captures
// the gate output F for each vector into a truth table, and grades the
// captured table against a golden table.
`timescale 1ns/1ps

module aoi_truth_scanner #(
    parameter int          SETTLE   = 1,
    parameter logic [31:0] EXPECTED = 32'h0777_7777
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        E,
    input  logic        F,
    output logic        busy,
    output logic        done,
    output logic [31:0] truth_tbl,
    output logic [5:0]  err_cnt,
    output logic [4:0]  fail_idx,
    output logic        pass
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] truth_q, truth_d;
    logic [5:0]  err_q, err_d;
    logic [4:0]  fail_q, fail_d;
    logic        pass_q, pass_d;
    logic        done_q, done_d;

    // State and datapath registers; synchronous active-low reset aborts any run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            cnt_q   <= 4'd0;
            truth_q <= 32'd0;
            err_q   <= 6'd0;
            fail_q  <= 5'd0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            truth_q <= truth_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    // Next state: start is only honoured in IDLE; the run ends after vector 31 is sampled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = WAIT;
            WAIT: if (cnt_q == 4'd0 && idx_q == 5'd31) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: settle countdown, F capture, grading and completion flags.
    always_comb begin
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        truth_d = truth_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                idx_d   = 5'd0;
                cnt_d   = SETTLE_CNT;
                truth_d = 32'd0;
                err_d   = 6'd0;
                fail_d  = 5'd0;
                pass_d  = 1'b0;
            end
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            truth_d[idx_q] = F;
            if (F != EXPECTED[idx_q]) begin
                err_d = err_q + 6'd1;
                if (err_q == 6'd0) fail_d = idx_q;
            end
            if (idx_q == 5'd31) begin
                done_d = 1'b1;
                pass_d = (err_d == 6'd0);
            end else begin
                idx_d = idx_q + 5'd1;
                cnt_d = SETTLE_CNT;
            end
        end
    end

    // Outputs: stimulus comes straight from the registered vector index.
    always_comb begin
        {A, B, C, D, E} = idx_q;
        busy      = (state_q == WAIT);
        done      = done_q;
        truth_tbl = truth_q;
        err_cnt   = err_q;
        fail_idx  = fail_q;
        pass      = pass_q;
    end

endmodule

// File: tb/tb_aoi_truth_scanner.sv
// tb_aoi_truth_scanner
// Directed bench for the AOI truth-table scanner: three instances with
// SETTLE = 0, 1 and 3 share the clock and reset; a behavioural gate model
// (correct, stuck-at-1 or stuck-at-0) closes each loop from A..E back to F.
`timescale 1ns/1ps

module tb_aoi_truth_scanner;

    logic clk;
    logic rst_n;
    logic startReq;
    int   sel;
    int   mode;

    int nCompared;
    int nMismatched;

    wire [4:0]  vec0, vec1, vec3;
    wire        busy0, busy1, busy3;
    wire        done0, done1, done3;
    wire [31:0] tbl0, tbl1, tbl3;
    wire [5:0]  err0, err1, err3;
    wire [4:0]  fail0, fail1, fail3;
    wire        pass0, pass1, pass3;
    logic       f0, f1, f3;
    logic       start0, start1, start3;

    logic [4:0]  vecM;
    logic        busyM, doneM, passM;
    logic [31:0] tblM;
    logic [5:0]  errM;
    logic [4:0]  failM;

    // Behavioural gate under test, selectable between correct and stuck faults.
    function automatic logic gateF(input logic [4:0] v, input int m);
        case (m)
            1:       return 1'b1;
            2:       return 1'b0;
            default: return ~((v[4] & v[3] & v[2]) | (v[1] & v[0]));
        endcase
    endfunction

    assign f0 = gateF(vec0, mode);
    assign f1 = gateF(vec1, mode);
    assign f3 = gateF(vec3, mode);
    assign start0 = startReq && (sel == 0);
    assign start1 = startReq && (sel == 1);
    assign start3 = startReq && (sel == 3);

    aoi_truth_scanner #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .A(vec0[4]), .B(vec0[3]), .C(vec0[2]), .D(vec0[1]), .E(vec0[0]),
        .F(f0), .busy(busy0), .done(done0), .truth_tbl(tbl0),
        .err_cnt(err0), .fail_idx(fail0), .pass(pass0)
    );

    aoi_truth_scanner #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .A(vec1[4]), .B(vec1[3]), .C(vec1[2]), .D(vec1[1]), .E(vec1[0]),
        .F(f1), .busy(busy1), .done(done1), .truth_tbl(tbl1),
        .err_cnt(err1), .fail_idx(fail1), .pass(pass1)
    );

    aoi_truth_scanner #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .A(vec3[4]), .B(vec3[3]), .C(vec3[2]), .D(vec3[1]), .E(vec3[0]),
        .F(f3), .busy(busy3), .done(done3), .truth_tbl(tbl3),
        .err_cnt(err3), .fail_idx(fail3), .pass(pass3)
    );

    // Route the currently selected instance onto one set of observation signals.
    always_comb begin
        vecM = vec1; busyM = busy1; doneM = done1; tblM = tbl1;
        errM = err1; failM = fail1; passM = pass1;
        case (sel)
            0: begin
                vecM = vec0; busyM = busy0; doneM = done0; tblM = tbl0;
                errM = err0; failM = fail0; passM = pass0;
            end
            3: begin
                vecM = vec3; busyM = busy3; doneM = done3; tblM = tbl3;
                errM = err3; failM = fail3; passM = pass3;
            end
            default: ;
        endcase
    end

    // 10 ns free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Count edges after an acceptance edge until done; optionally inject
    // ignored start pulses, a start held through done, or a mid-run reset.
    task automatic waitDone(input int pulse1, input int pulse2, input int holdFrom,
                            input int resetAt, output int latency, output bit vecOk,
                            output bit sawDone);
        int settle;
        settle  = (sel == 0) ? 0 : (sel == 3) ? 3 : 1;
        latency = -1;
        vecOk   = 1'b1;
        sawDone = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            startReq = (c == pulse1) || (c == pulse2) || (holdFrom > 0 && c >= holdFrom);
            rst_n    = !(c == resetAt);
            @(posedge clk);
            #1;
            if (c == resetAt) begin
                rst_n = 1'b1;
                checkOutput("reset_ctrl", {vecM, busyM, doneM, passM, errM, failM}, 32'd0);
                checkOutput("reset_tbl", tblM, 32'd0);
            end
            if (doneM) sawDone = 1'b1;
            if (doneM && latency < 0) latency = c;
            if (resetAt == 0 && latency < 0 && c < 32 * (settle + 1))
                if (vecM !== 5'(c / (settle + 1))) vecOk = 1'b0;
            if (resetAt > 0 && c >= resetAt + 100) break;
            if (resetAt == 0 && latency >= 0 && c >= latency + (holdFrom > 0 ? 1 : 0)) break;
        end
        if (resetAt == 0 && latency < 0)
            checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    // Issue a start to the selected instance, check the acceptance edge, then wait for done.
    task automatic applyStimulus(input int pulse1, input int pulse2, input int holdFrom,
                                 input int resetAt, output int latency, output bit vecOk,
                                 output bit sawDone);
        startReq = 1'b1;
        @(posedge clk);
        #1;
        startReq = 1'b0;
        checkOutput("accept_busy", {31'd0, busyM}, 32'd1);
        checkOutput("accept_vec", {27'd0, vecM}, 32'd0);
        waitDone(pulse1, pulse2, holdFrom, resetAt, latency, vecOk, sawDone);
    endtask

    initial begin
        int lat;
        bit vok;
        bit sd;
        nCompared   = 0;
        nMismatched = 0;
        startReq    = 1'b0;
        sel         = 1;
        mode        = 0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ctrl0", {vecM, busyM, doneM, passM, errM, failM}, 32'd0);
        checkOutput("reset_tbl0", tblM, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] correct gate, SETTLE=1");
        applyStimulus(0, 0, 0, 0, lat, vok, sd);
        checkOutput("good_latency", lat, 32'd64);
        checkOutput("good_vec_walk", {31'd0, vok}, 32'd1);
        checkOutput("good_busy_low", {31'd0, busyM}, 32'd0);
        checkOutput("good_tbl", tblM, 32'h0777_7777);
        checkOutput("good_err", {26'd0, errM}, 32'd0);
        checkOutput("good_fail", {27'd0, failM}, 32'd0);
        checkOutput("good_pass", {31'd0, passM}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", {31'd0, doneM}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("results_held", tblM, 32'h0777_7777);

        $display("[TB] F stuck at 1");
        mode = 1;
        applyStimulus(0, 0, 0, 0, lat, vok, sd);
        checkOutput("st1_tbl", tblM, 32'hFFFF_FFFF);
        checkOutput("st1_err", {26'd0, errM}, 32'd11);
        checkOutput("st1_fail", {27'd0, failM}, 32'd3);
        checkOutput("st1_pass", {31'd0, passM}, 32'd0);

        $display("[TB] F stuck at 0");
        mode = 2;
        applyStimulus(0, 0, 0, 0, lat, vok, sd);
        checkOutput("st0_tbl", tblM, 32'h0000_0000);
        checkOutput("st0_err", {26'd0, errM}, 32'd21);
        checkOutput("st0_fail", {27'd0, failM}, 32'd0);
        checkOutput("st0_pass", {31'd0, passM}, 32'd0);

        $display("[TB] ignored start pulses, start held through done");
        mode = 0;
        applyStimulus(5, 30, 63, 0, lat, vok, sd);
        checkOutput("pulse_latency", lat, 32'd64);
        checkOutput("rerun_busy", {31'd0, busyM}, 32'd1);
        checkOutput("rerun_tbl_clr", tblM, 32'd0);
        checkOutput("rerun_err_clr", {26'd0, errM}, 32'd0);
        checkOutput("rerun_pass_clr", {31'd0, passM}, 32'd0);
        checkOutput("rerun_vec", {27'd0, vecM}, 32'd0);
        waitDone(0, 0, 0, 0, lat, vok, sd);
        checkOutput("rerun_latency", lat, 32'd64);
        checkOutput("rerun_pass", {31'd0, passM}, 32'd1);

        $display("[TB] reset mid-run");
        applyStimulus(0, 0, 0, 20, lat, vok, sd);
        checkOutput("reset_no_done", {31'd0, sd}, 32'd0);
        applyStimulus(0, 0, 0, 0, lat, vok, sd);
        checkOutput("after_rst_latency", lat, 32'd64);
        checkOutput("after_rst_pass", {31'd0, passM}, 32'd1);

        $display("[TB] SETTLE=0");
        sel = 0;
        applyStimulus(0, 0, 0, 0, lat, vok, sd);
        checkOutput("s0_latency", lat, 32'd32);
        checkOutput("s0_vec_walk", {31'd0, vok}, 32'd1);
        checkOutput("s0_tbl", tblM, 32'h0777_7777);
        checkOutput("s0_pass", {31'd0, passM}, 32'd1);

        $display("[TB] SETTLE=3");
        sel = 3;
        applyStimulus(0, 0, 0, 0, lat, vok, sd);
        checkOutput("s3_latency", lat, 32'd128);
        checkOutput("s3_vec_walk", {31'd0, vok}, 32'd1);
        checkOutput("s3_tbl", tblM, 32'h0777_7777);
        checkOutput("s3_pass", {31'd0, passM}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
